// File: rtl/wb_pkg.sv
// Shared types and width helpers for the Wishbone arbiter.
package wb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } wb_arb_state_e;

    // Index width for n masters; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the values 0..n inclusive.
    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/wb_arb_picker.sv
// Combinational winner picker. WB_ARB_ROUND_ROBIN_EN selects round-robin
// search from ptr+1; otherwise the lowest requesting index wins.
module wb_arb_picker #(
    parameter int N  = 2,
    parameter int GW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [GW-1:0] idx,
    output logic          valid
);

    assign valid  = |req;
    assign onehot = valid ? (N'(1) << idx) : '0;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                idx   = GW'((int'(ptr) + k) % N);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                idx = GW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Pipelined Wishbone B4 N:1 arbiter with bounded outstanding transfers.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration (fixed priority otherwise).
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]   m_adr_i,
    input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]   m_dat_i,
    output logic [NUM_MASTERS-1:0]               m_stall_o,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic [DATA_W-1:0]                    m_dat_o,
    output logic                                 s_cyc_o,
    output logic                                 s_stb_o,
    output logic                                 s_we_o,
    output logic [ADDR_W-1:0]                    s_adr_o,
    output logic [DATA_W/8-1:0]                  s_sel_o,
    output logic [DATA_W-1:0]                    s_dat_o,
    input  logic                                 s_stall_i,
    input  logic                                 s_ack_i,
    input  logic                                 s_err_i,
    input  logic [DATA_W-1:0]                    s_dat_i
);

    localparam int GW = grant_w(NUM_MASTERS);
    localparam int CW = count_w(MAX_OUTSTANDING);

    wb_arb_state_e          state_reg;
    logic [GW-1:0]          grant_reg;
    logic [CW-1:0]          count_reg;
    logic [GW-1:0]          pick_ptr;
    logic [GW-1:0]          pick_idx;
    logic [NUM_MASTERS-1:0] unused_pick_onehot;
    logic                   pick_valid;

    logic owned;
    logic owner_cyc;
    logic resp;
    logic full;
    logic accept;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [GW-1:0] rr_ptr_reg;
    assign pick_ptr = rr_ptr_reg;
`else
    assign pick_ptr = '0;
`endif

    wb_arb_picker #(
        .N  (NUM_MASTERS),
        .GW (GW)
    ) u_picker (
        .req    (m_cyc_i),
        .ptr    (pick_ptr),
        .onehot (unused_pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign owned     = (state_reg == OWNED);
    assign owner_cyc = m_cyc_i[grant_reg];
    assign resp      = s_ack_i || s_err_i;
    // A response at the limit frees its slot for a new strobe in the same cycle.
    assign full      = (count_reg == CW'(MAX_OUTSTANDING)) && !resp;

    assign s_cyc_o = owned && owner_cyc;
    assign s_stb_o = owned && owner_cyc && m_stb_i[grant_reg] && !full;
    assign s_we_o  = m_we_i[grant_reg];
    assign s_adr_o = m_adr_i[grant_reg];
    assign s_sel_o = m_sel_i[grant_reg];
    assign s_dat_o = m_dat_i[grant_reg];
    assign m_dat_o = s_dat_i;
    assign accept  = s_stb_o && !s_stall_i;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            logic is_owner;
            assign is_owner      = owned && (grant_reg == GW'(gi));
            assign m_stall_o[gi] = is_owner ? (s_stall_i || full) : 1'b1;
            assign m_ack_o[gi]   = is_owner && s_ack_i;
            assign m_err_o[gi]   = is_owner && s_err_i;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            count_reg  <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            rr_ptr_reg <= GW'(NUM_MASTERS - 1);
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_reg  <= pick_idx;
                        state_reg  <= OWNED;
`ifdef WB_ARB_ROUND_ROBIN_EN
                        rr_ptr_reg <= pick_idx;
`endif
                    end
                end
                OWNED: begin
                    // Releasing abandons any transfers still in flight.
                    if (!owner_cyc) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end else if (accept && !resp) begin
                        count_reg <= count_reg + CW'(1);
                    end else if (!accept && resp && (count_reg != '0)) begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: 2 masters, MAX_OUTSTANDING=2.
module tb_wb_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NM-1:0]          m_cyc, m_stb, m_we;
    logic [NM-1:0][AW-1:0]  m_adr;
    logic [NM-1:0][DW/8-1:0] m_sel;
    logic [NM-1:0][DW-1:0]  m_dat;
    logic [NM-1:0]          m_stall_o, m_ack_o, m_err_o;
    logic [DW-1:0]          m_dat_o;
    logic                   s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]          s_adr_o;
    logic [DW/8-1:0]        s_sel_o;
    logic [DW-1:0]          s_dat_o;
    logic                   s_stall, s_ack, s_err;
    logic [DW-1:0]          s_dat;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUM_MASTERS     (NM),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_adr_i   (m_adr),
        .m_sel_i   (m_sel),
        .m_dat_i   (m_dat),
        .m_stall_o (m_stall_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_dat_o   (m_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_sel_o   (s_sel_o),
        .s_dat_o   (s_dat_o),
        .s_stall_i (s_stall),
        .s_ack_i   (s_ack),
        .s_err_i   (s_err),
        .s_dat_i   (s_dat)
    );

    typedef struct {
        logic [1:0] cyc;
        logic [1:0] stb;
        logic       st;
        logic       ak;
        logic       er;
        logic       e_cyc;
        logic       e_stb;
        logic [1:0] e_stall;
        logic [1:0] e_ack;
        logic [1:0] e_err;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] rdata(input int n);
        return 32'hA5000000 | (32'h100 + 32'(4 * n));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int owners[3];
        int cyc_n;
        int sent;
        int got;
        logic [31:0] exp_q[$];
        int          slv_t[$];
        logic [31:0] slv_d[$];

        idle_inputs();
        m_adr[0] = 32'h100; m_adr[1] = 32'h200;
        m_sel[0] = 4'hF;    m_sel[1] = 4'h3;
        m_dat[0] = 32'h11111111; m_dat[1] = 32'h22222222;

        //          cyc    stb   st    ak    er    ecyc  estb  estall eack   eerr
        tbl[0]  = '{2'b00,2'b00,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b11,2'b00,2'b00};
        tbl[1]  = '{2'b01,2'b00,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b11,2'b00,2'b00};
        tbl[2]  = '{2'b01,2'b01,1'b0,1'b0,1'b0, 1'b1,1'b1,2'b10,2'b00,2'b00};
        tbl[3]  = '{2'b01,2'b01,1'b1,1'b0,1'b0, 1'b1,1'b1,2'b11,2'b00,2'b00};
        tbl[4]  = '{2'b01,2'b01,1'b0,1'b0,1'b0, 1'b1,1'b1,2'b10,2'b00,2'b00};
        tbl[5]  = '{2'b01,2'b01,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b11,2'b00,2'b00};
        tbl[6]  = '{2'b01,2'b01,1'b0,1'b1,1'b0, 1'b1,1'b1,2'b10,2'b01,2'b00};
        tbl[7]  = '{2'b01,2'b00,1'b0,1'b0,1'b1, 1'b1,1'b0,2'b10,2'b00,2'b01};
        tbl[8]  = '{2'b01,2'b00,1'b0,1'b1,1'b0, 1'b1,1'b0,2'b10,2'b01,2'b00};
        tbl[9]  = '{2'b01,2'b00,1'b0,1'b1,1'b0, 1'b1,1'b0,2'b10,2'b01,2'b00};
        tbl[10] = '{2'b01,2'b01,1'b0,1'b0,1'b0, 1'b1,1'b1,2'b10,2'b00,2'b00};
        tbl[11] = '{2'b01,2'b01,1'b0,1'b0,1'b0, 1'b1,1'b1,2'b10,2'b00,2'b00};
        tbl[12] = '{2'b01,2'b01,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b11,2'b00,2'b00};
        tbl[13] = '{2'b00,2'b00,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b11,2'b00,2'b00};
        tbl[14] = '{2'b00,2'b00,1'b0,1'b1,1'b0, 1'b0,1'b0,2'b11,2'b00,2'b00};
        tbl[15] = '{2'b10,2'b00,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b11,2'b00,2'b00};
        tbl[16] = '{2'b10,2'b10,1'b0,1'b0,1'b0, 1'b1,1'b1,2'b01,2'b00,2'b00};
        tbl[17] = '{2'b10,2'b10,1'b0,1'b1,1'b0, 1'b1,1'b1,2'b01,2'b10,2'b00};
        tbl[18] = '{2'b00,2'b00,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b01,2'b00,2'b00};
        tbl[19] = '{2'b00,2'b00,1'b0,1'b0,1'b0, 1'b0,1'b0,2'b11,2'b00,2'b00};

        // Table: handshake, outstanding limit, underflow guard, abort and late ack.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            m_cyc = tbl[i].cyc; m_stb = tbl[i].stb;
            s_stall = tbl[i].st; s_ack = tbl[i].ak; s_err = tbl[i].er;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {s_cyc_o, s_stb_o, m_stall_o, m_ack_o, m_err_o},
                  {tbl[i].e_cyc, tbl[i].e_stb, tbl[i].e_stall, tbl[i].e_ack, tbl[i].e_err});
            $display("vec %0d: cyc=%b stb=%b -> s_cyc=%b s_stb=%b stall=%b ack=%b err=%b",
                     i, m_cyc, m_stb, s_cyc_o, s_stb_o, m_stall_o, m_ack_o, m_err_o);
            next_cycle();
        end

        // Single master: three pipelined reads, slave acks two cycles after acceptance.
        do_reset();
        m_cyc = 2'b01;
        sent = 0; got = 0;
        for (cyc_n = 0; cyc_n < 30 && got < 3; cyc_n++) begin
            m_stb[0] = (sent < 3);
            m_adr[0] = 32'h100 + 32'(4 * sent);
            s_ack = (slv_t.size() > 0) && (slv_t[0] == cyc_n);
            s_dat = s_ack ? slv_d[0] : 32'hDEADBEEF;
            @(negedge clk);
            if (cyc_n == 0) check("latency_idle", s_cyc_o, 1'b0);
            if (cyc_n == 1) check("latency_owned", s_cyc_o, 1'b1);
            check($sformatf("m1_stall_c%0d", cyc_n), m_stall_o[1], 1'b1);
            if (m_stb[0] && !m_stall_o[0]) begin
                check("accept_agree", s_stb_o, 1'b1);
                check($sformatf("adr%0d", sent), s_adr_o, 32'h100 + 32'(4 * sent));
                slv_t.push_back(cyc_n + 2);
                slv_d.push_back(rdata(sent));
                exp_q.push_back(rdata(sent));
                $display("read %0d accepted at cycle %0d", sent, cyc_n);
                sent++;
            end
            if (s_ack) begin
                void'(slv_t.pop_front());
                void'(slv_d.pop_front());
            end
            if (m_ack_o[0]) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_ack: got ack at cycle %0d, wanted none", cyc_n);
                end else begin
                    check($sformatf("rdata%0d", got), m_dat_o, exp_q.pop_front());
                    $display("read %0d acked at cycle %0d data=%h", got, cyc_n, m_dat_o);
                end
                got++;
            end
            next_cycle();
        end
        if (got < 3) begin
            n_vec++; n_err++;
            $display("FAIL read_timeout: got %0d acks, wanted 3", got);
        end
        idle_inputs();
        @(negedge clk);
        check("single_release", s_cyc_o, 1'b0);
        next_cycle();

        // Contention: owner releases for one cycle and re-requests during IDLE.
`ifdef WB_ARB_ROUND_ROBIN_EN
        owners = '{0, 1, 0};
`else
        owners = '{0, 0, 0};
`endif
        do_reset();
        m_cyc = 2'b11;
        @(negedge clk);
        check("arb_first_idle", s_cyc_o, 1'b0);
        next_cycle();
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check($sformatf("arb_owner%0d", r), m_stall_o, (owners[r] == 0) ? 2'b10 : 2'b01);
            check($sformatf("arb_cyc%0d", r), s_cyc_o, 1'b1);
            $display("round %0d: stall=%b s_cyc=%b", r, m_stall_o, s_cyc_o);
            next_cycle();
            m_cyc[owners[r]] = 1'b0;
            @(negedge clk);
            check($sformatf("arb_release%0d", r), s_cyc_o, 1'b0);
            next_cycle();
            m_cyc = 2'b11;
            @(negedge clk);
            check($sformatf("arb_gap%0d", r), {s_cyc_o, m_stall_o}, 3'b011);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();

        // Asynchronous reset in the middle of a burst.
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01;
        next_cycle();
        next_cycle();
        check("pre_reset_cyc", s_cyc_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("reset_cyc", {s_cyc_o, s_stb_o}, 2'b00);
        check("reset_stall", m_stall_o, 2'b11);
        $display("mid-burst reset: s_cyc=%b stall=%b", s_cyc_o, m_stall_o);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_inputs();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
